// File: rtl/i2c_cfg_pkg.sv
// ---------------------------------------------------------------------------
// i2c_cfg_pkg
// Shared types and constants for the I2C register-init sequencer.
//   state_t      : sequencer FSM states
//   cfg_entry_t  : one external table entry {reg_addr, payload}
//   BITS_PER_XFER: data + ACK bit times in one 3-byte write (3 x 9)
//   QUARTERS     : tick periods per I2C bit
// ---------------------------------------------------------------------------
package i2c_cfg_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    START,
    BYTE,
    ACK,
    STOP,
    NEXT,
    DONE,
    ERR
  } state_t;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] payload;
  } cfg_entry_t;

  localparam int BITS_PER_XFER = 27;
  localparam int QUARTERS      = 4;

endpackage

// File: rtl/i2c_tick_gen.sv
// ---------------------------------------------------------------------------
// i2c_tick_gen
// Quarter-bit timebase for the I2C bit engine. While en_i is high a counter
// runs modulo CLK_DIV and emits a one-cycle tick_o at the end of each
// quarter; quarter_o counts the quarter (0..3) of the current bit. Dropping
// en_i clears both counters so the next enable starts cleanly at Q0.
// Ports:
//   clock     in  system clock
//   reset     in  synchronous, active-low
//   en_i      in  run enable
//   tick_o    out last clock of the current quarter
//   quarter_o out current quarter of the bit
// ---------------------------------------------------------------------------
module i2c_tick_gen
  import i2c_cfg_pkg::*;
#(
  parameter int CLK_DIV = 63
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en_i,
  output logic       tick_o,
  output logic [1:0] quarter_o
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    quarter_q, quarter_d;

  assign tick_o    = en_i && (cnt_q == CW'(CLK_DIV - 1));
  assign quarter_o = quarter_q;

  always_comb begin
    cnt_d     = cnt_q;
    quarter_d = quarter_q;
    if (!en_i) begin
      cnt_d     = '0;
      quarter_d = '0;
    end else if (tick_o) begin
      cnt_d     = '0;
      quarter_d = (quarter_q == 2'(QUARTERS - 1)) ? 2'd0 : quarter_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q     <= '0;
      quarter_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      quarter_q <= quarter_d;
    end
  end

endmodule

// File: rtl/i2c_init_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_init_sequencer
// Walks an external table of {reg_addr, payload} entries and writes each one
// to DEV_ADDR as a 3-byte I2C write (START, dev, reg, data, STOP). Drives the
// open-drain SCL/SDA pads and reports busy/done/error.
// Optional build macro: I2C_INIT_RETRY_EN -- re-send a NACKed entry up to
// MAX_RETRY extra times before flagging an error.
// Ports:
//   clock, reset        system clock, synchronous active-low reset
//   start               one-cycle run request (ignored while busy)
//   table_index         entry requested from the table
//   table_data          {reg_addr, payload}, valid 1 clock after table_index
//   busy/done/error     run status; done/error held until next start
//   error_index         failing entry while error=1
//   scl_oe, sda_oe      1 = pull pad low, 0 = release
//   sda_i               SDA pad input
// ---------------------------------------------------------------------------
module i2c_init_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int         CLK_DIV   = 63,
  parameter logic [7:0] DEV_ADDR  = 8'h72,
  parameter int         NUM_REGS  = 12,
  parameter int         IDX_W     = 6,
  parameter int         MAX_RETRY = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] table_index,
  input  logic [15:0]      table_data,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] error_index,
  output logic             scl_oe,
  input  logic             sda_i,
  output logic             sda_oe
);

  if (CLK_DIV < 2 || NUM_REGS < 0 || MAX_RETRY < 0 || NUM_REGS > (1 << IDX_W)) begin : g_bad_params
    $error("i2c_init_sequencer: illegal parameter set");
  end

  localparam int               LAST_BYTE = BITS_PER_XFER / 9 - 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = (NUM_REGS == 0) ? '0 : IDX_W'(NUM_REGS - 1);

  state_t           state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [IDX_W-1:0] table_index_q, table_index_d, error_index_q, error_index_d;
  logic [23:0]      shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic             fetch_wait_q, fetch_wait_d;
  logic             nack_q, nack_d;
  logic             ack_bit_q, ack_bit_d;
  logic             scl_oe_q, sda_oe_q;
  logic             scl_low, sda_low;
  logic             tick, tick_en, bit_end;
  logic [1:0]       quarter;
  cfg_entry_t       entry;

`ifdef I2C_INIT_RETRY_EN
  localparam int RETRY_W = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_q, retry_d;
`endif

  assign entry   = cfg_entry_t'(table_data);
  // Timebase only runs while the bus is being driven, so every START lands on Q0.
  assign tick_en = state_q inside {START, BYTE, ACK, STOP};
  assign bit_end = tick && (quarter == 2'(QUARTERS - 1));

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clock    (clock),
    .reset    (reset),
    .en_i     (tick_en),
    .tick_o   (tick),
    .quarter_o(quarter)
  );

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = done_q;
    error_d       = error_q;
    error_index_d = error_index_q;
    table_index_d = table_index_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    fetch_wait_d  = fetch_wait_q;
    nack_d        = nack_q;
    ack_bit_d     = ack_bit_q;
`ifdef I2C_INIT_RETRY_EN
    retry_d       = retry_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d       = FETCH;
        busy_d        = 1'b1;
        done_d        = 1'b0;
        error_d       = 1'b0;
        table_index_d = '0;
        fetch_wait_d  = 1'b0;
`ifdef I2C_INIT_RETRY_EN
        retry_d       = '0;
`endif
      end
      FETCH: begin
        if (NUM_REGS == 0) begin
          state_d = DONE;
        end else if (!fetch_wait_q) begin
          fetch_wait_d = 1'b1;           // table_data lags table_index by a clock
        end else begin
          shift_d      = {DEV_ADDR, entry.reg_addr, entry.payload};
          bit_cnt_d    = '0;
          byte_cnt_d   = '0;
          nack_d       = 1'b0;
          fetch_wait_d = 1'b0;
          state_d      = START;
        end
      end
      START: if (bit_end) state_d = BYTE;
      BYTE: if (bit_end) begin
        shift_d = {shift_q[22:0], 1'b0};
        if (bit_cnt_q == 3'd7) begin
          bit_cnt_d = '0;
          state_d   = ACK;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      ACK: begin
        if (tick && quarter == 2'd2) ack_bit_d = sda_i;
        if (bit_end) begin
          if (ack_bit_q) begin
            nack_d  = 1'b1;
            state_d = STOP;
          end else if (byte_cnt_q == 2'(LAST_BYTE)) begin
            state_d = STOP;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            state_d    = BYTE;
          end
        end
      end
      STOP: if (bit_end) begin
        if (!nack_q) begin
          state_d = NEXT;
        end else begin
`ifdef I2C_INIT_RETRY_EN
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = FETCH;              // same table_index: re-send this entry
          end else begin
            state_d = ERR;
          end
`else
          state_d = ERR;
`endif
        end
      end
      NEXT: begin
        if (table_index_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          table_index_d = table_index_q + IDX_W'(1);
          state_d       = FETCH;
`ifdef I2C_INIT_RETRY_EN
          retry_d       = '0;
`endif
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        busy_d        = 1'b0;
        error_d       = 1'b1;
        error_index_d = table_index_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pad drive per bit quarter. SCL is low in Q0/Q3 of data/ACK bits, so SDA
  // (which changes only at a bit boundary) never moves while SCL is high.
  always_comb begin
    scl_low = 1'b0;
    sda_low = 1'b0;
    case (state_q)
      START: begin
        scl_low = (quarter == 2'd3);
        sda_low = quarter[1];            // falls at Q2 with SCL high
      end
      BYTE: begin
        scl_low = (quarter == 2'd0) || (quarter == 2'd3);
        sda_low = ~shift_q[23];
      end
      ACK: scl_low = (quarter == 2'd0) || (quarter == 2'd3);
      STOP: begin
        scl_low = (quarter == 2'd0);
        sda_low = (quarter != 2'd3);     // rises at Q3 with SCL high
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      error_index_q <= '0;
      table_index_q <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      fetch_wait_q  <= 1'b0;
      nack_q        <= 1'b0;
      ack_bit_q     <= 1'b0;
      scl_oe_q      <= 1'b0;
      sda_oe_q      <= 1'b0;
`ifdef I2C_INIT_RETRY_EN
      retry_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      error_index_q <= error_index_d;
      table_index_q <= table_index_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      fetch_wait_q  <= fetch_wait_d;
      nack_q        <= nack_d;
      ack_bit_q     <= ack_bit_d;
      scl_oe_q      <= scl_low;
      sda_oe_q      <= sda_low;
`ifdef I2C_INIT_RETRY_EN
      retry_q       <= retry_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign error_index = error_index_q;
  assign table_index = table_index_q;
  assign scl_oe      = scl_oe_q;
  assign sda_oe      = sda_oe_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_init_sequencer
// Directed bench: ADV7513-style slave model on an open-drain bus with
// pull-ups, a 3-entry register table, and a second instance with an empty
// table. A bus monitor checks SDA stability and SCL high/low widths.
// Define I2C_INIT_RETRY_EN for both RTL and bench to exercise retries.
// ---------------------------------------------------------------------------
module tb_i2c_init_sequencer;

  localparam int CLK_DIV = 4;
  localparam int IDX_W   = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W-1:0] table_index, error_index;
  logic [15:0]      table_data = 16'h0000;
  logic             busy, done, error, scl_oe, sda_oe, sda_i;

  logic             start0 = 1'b0;
  logic [IDX_W-1:0] table_index0, error_index0;
  logic [15:0]      table_data0 = 16'h0000;
  logic             busy0, done0, error0, scl_oe0, sda_oe0, sda_i0;

  logic slv_oe = 1'b0;
  logic scl_bus, sda_bus;
  assign scl_bus = ~scl_oe;
  assign sda_bus = ~(sda_oe | slv_oe);
  assign sda_i   = sda_bus;
  assign sda_i0  = ~sda_oe0;

  i2c_init_sequencer #(.CLK_DIV(CLK_DIV), .DEV_ADDR(8'h72), .NUM_REGS(3), .IDX_W(IDX_W), .MAX_RETRY(3)) u_dut (
    .clock(clk), .reset(rst_n), .start(start), .table_index(table_index), .table_data(table_data),
    .busy(busy), .done(done), .error(error), .error_index(error_index),
    .scl_oe(scl_oe), .sda_i(sda_i), .sda_oe(sda_oe)
  );

  i2c_init_sequencer #(.CLK_DIV(CLK_DIV), .DEV_ADDR(8'h72), .NUM_REGS(0), .IDX_W(IDX_W), .MAX_RETRY(3)) u_dut0 (
    .clock(clk), .reset(rst_n), .start(start0), .table_index(table_index0), .table_data(table_data0),
    .busy(busy0), .done(done0), .error(error0), .error_index(error_index0),
    .scl_oe(scl_oe0), .sda_i(sda_i0), .sda_oe(sda_oe0)
  );

  // External register table, one clock of read latency.
  always @(posedge clk) begin
    case (table_index)
      6'd0:    table_data <= 16'h4100;
      6'd1:    table_data <= 16'h9803;
      6'd2:    table_data <= 16'h9A70;
      default: table_data <= 16'hFFFF;
    endcase
  end

  logic [7:0] exp_all [0:8] = '{8'h72, 8'h41, 8'h00, 8'h72, 8'h98, 8'h03, 8'h72, 8'h9A, 8'h70};

  int checks = 0;
  int errors = 0;

  // Slave model / bus monitor controls (written by tasks only)
  logic bfm_clr = 1'b0;
  logic chk_en  = 1'b0;
  int   nack_byte = -1;
  int   nack_from = 0;
  int   nack_to   = -1;

  // Slave model / bus monitor state (written by the monitor only)
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic [7:0] shreg = 8'h00;
  logic [7:0] got [$];
  int bfm_in = 0, bfm_bit = 0, bfm_ackph = 0, bfm_byte = 0;
  int xfer_num = 0, start_cnt = 0, stop_cnt = 0, txn_bytes = 0;
  int proto_viol = 0, run_len = 0, run_ok = 0;

  always @(negedge clk) begin
    if (bfm_clr) begin
      bfm_in = 0; bfm_bit = 0; bfm_ackph = 0; bfm_byte = 0; slv_oe = 1'b0;
      xfer_num = 0; start_cnt = 0; stop_cnt = 0; txn_bytes = 0;
      got.delete();
    end else begin
      if (chk_en && prev_scl && scl_bus && (sda_bus != prev_sda) && bfm_in != 0 &&
          !(bfm_bit <= 1 && bfm_ackph == 0)) begin
        proto_viol++;
        $display("proto: SDA moved with SCL high mid-byte at %0t", $time);
      end
      if (prev_scl && scl_bus && prev_sda && !sda_bus) begin
        start_cnt++; bfm_in = 1; bfm_bit = 0; bfm_ackph = 0; bfm_byte = 0; txn_bytes = 0; slv_oe = 1'b0;
      end else if (prev_scl && scl_bus && !prev_sda && sda_bus) begin
        stop_cnt++;
        $display("txn %0d: %0d bytes, last %02h", xfer_num, txn_bytes, shreg);
        bfm_in = 0; bfm_bit = 0; bfm_ackph = 0; slv_oe = 1'b0; xfer_num++;
      end else if (bfm_in != 0 && !prev_scl && scl_bus) begin
        if (bfm_ackph == 0) begin shreg = {shreg[6:0], sda_bus}; bfm_bit++; end
      end else if (bfm_in != 0 && prev_scl && !scl_bus) begin
        if (bfm_ackph != 0) begin
          slv_oe = 1'b0; bfm_ackph = 0; bfm_bit = 0; bfm_byte++;
        end else if (bfm_bit == 8) begin
          got.push_back(shreg); txn_bytes++; bfm_ackph = 1;
          slv_oe = !(xfer_num >= nack_from && xfer_num <= nack_to && bfm_byte == nack_byte);
        end
      end
    end
    if (!chk_en) run_ok = 0;
    if (scl_bus != prev_scl) begin
      if (chk_en && run_ok != 0 && run_len < 2 * CLK_DIV) begin
        proto_viol++;
        $display("proto: SCL level held only %0d clocks at %0t", run_len, $time);
      end
      run_len = 1; run_ok = 1;
    end else begin
      run_len++;
    end
    prev_scl = scl_bus;
    prev_sda = sda_bus;
  end

  task automatic bfm_reset();
    bfm_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bfm_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_finish(input int budget, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < budget) begin
      if (!busy && (done || error)) begin ok = 1'b1; break; end
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b want 0", error); end
    checks++; if (scl_oe !== 1'b0 || sda_oe !== 1'b0) begin errors++; $display("FAIL reset_pads: got scl_oe=%0b sda_oe=%0b want 0 0", scl_oe, sda_oe); end
    checks++; if (table_index !== 6'd0 || error_index !== 6'd0) begin errors++; $display("FAIL reset_index: got %0d/%0d want 0/0", table_index, error_index); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_vs_start: busy got %0b want 0", busy); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_lost_in_reset: busy got %0b want 0", busy); end
    chk_en = 1'b1;
  endtask

  task automatic test_all_ack();
    bit ok;
    nack_byte = -1;
    bfm_reset();
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL all_ack_busy: got %0b want 1", busy); end
    wait_finish(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL all_ack_timeout: finished=%0b want 1", ok); end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL all_ack_status: done=%0b busy=%0b error=%0b want 1 0 0", done, busy, error); end
    checks++; if (got.size() != 9) begin errors++; $display("FAIL all_ack_count: got %0d bytes want 9", got.size()); end
    for (int i = 0; i < 9 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_all[i]) begin errors++; $display("FAIL all_ack_byte%0d: got %02h want %02h", i, got[i], exp_all[i]); end
    end
    checks++; if (start_cnt != 3 || stop_cnt != 3) begin errors++; $display("FAIL all_ack_framing: starts=%0d stops=%0d want 3 3", start_cnt, stop_cnt); end
  endtask

  task automatic test_nack_error();
    bit ok;
    nack_byte = 1; nack_from = 1; nack_to = 1;
    bfm_reset();
    pulse_start();
    wait_finish(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL nack_timeout: finished=%0b want 1", ok); end
    checks++; if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL nack_status: error=%0b done=%0b busy=%0b want 1 0 0", error, done, busy); end
    checks++; if (error_index !== 6'd1) begin errors++; $display("FAIL nack_error_index: got %0d want 1", error_index); end
    checks++; if (got.size() != 5 || stop_cnt != 2) begin errors++; $display("FAIL nack_bytes: got %0d bytes %0d stops want 5 2", got.size(), stop_cnt); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_all[i]) begin errors++; $display("FAIL nack_byte%0d: got %02h want %02h", i, got[i], exp_all[i]); end
    end
    nack_byte = -1;
  endtask

  task automatic test_retry();
    bit ok;
    logic [7:0] exp_q [$];
    nack_byte = 0; nack_from = 0; nack_to = 1;
    bfm_reset();
    pulse_start();
    wait_finish(5000, ok);
    exp_q = '{8'h72, 8'h72, 8'h72, 8'h41, 8'h00, 8'h72, 8'h98, 8'h03, 8'h72, 8'h9A, 8'h70};
    checks++; if (!ok || done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL retry_ok_status: done=%0b error=%0b want 1 0", done, error); end
    checks++; if (start_cnt != 5 || got.size() != 11) begin errors++; $display("FAIL retry_ok_count: starts=%0d bytes=%0d want 5 11", start_cnt, got.size()); end
    for (int i = 0; i < 11 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL retry_ok_byte%0d: got %02h want %02h", i, got[i], exp_q[i]); end
    end
    nack_byte = 0; nack_from = 0; nack_to = 3;
    bfm_reset();
    pulse_start();
    wait_finish(5000, ok);
    checks++; if (!ok || error !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL retry_exhaust_status: error=%0b done=%0b want 1 0", error, done); end
    checks++; if (error_index !== 6'd0) begin errors++; $display("FAIL retry_exhaust_index: got %0d want 0", error_index); end
    checks++; if (start_cnt != 4 || got.size() != 4) begin errors++; $display("FAIL retry_exhaust_count: starts=%0d bytes=%0d want 4 4", start_cnt, got.size()); end
    nack_byte = -1;
  endtask

  task automatic test_reset_mid_xfer();
    bit ok;
    int n;
    nack_byte = -1;
    bfm_reset();
    pulse_start();
    n = 0;
    while (!(bfm_in != 0 && bfm_byte == 1 && bfm_bit == 3) && n < 2000) begin @(negedge clk); n++; end
    checks++; if (n >= 2000) begin errors++; $display("FAIL midreset_reach: waited %0d clocks want < 2000", n); end
    chk_en = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (scl_oe !== 1'b0 || sda_oe !== 1'b0) begin errors++; $display("FAIL midreset_pads: scl_oe=%0b sda_oe=%0b want 0 0", scl_oe, sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %0b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    bfm_reset();
    chk_en = 1'b1;
    pulse_start();
    wait_finish(3000, ok);
    checks++; if (!ok || done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL midreset_rerun: done=%0b error=%0b want 1 0", done, error); end
    checks++; if (got.size() != 9) begin errors++; $display("FAIL midreset_count: got %0d bytes want 9", got.size()); end
    for (int i = 0; i < 9 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_all[i]) begin errors++; $display("FAIL midreset_byte%0d: got %02h want %02h", i, got[i], exp_all[i]); end
    end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    nack_byte = -1;
    bfm_reset();
    pulse_start();
    repeat (300) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid_run: got %0b want 1", busy); end
    pulse_start();
    wait_finish(3000, ok);
    checks++; if (!ok || done !== 1'b1) begin errors++; $display("FAIL busy_restart_done: done=%0b want 1", done); end
    checks++; if (got.size() != 9 || start_cnt != 3) begin errors++; $display("FAIL busy_restart_seq: bytes=%0d starts=%0d want 9 3", got.size(), start_cnt); end
  endtask

  task automatic test_empty_table();
    int   n;
    logic scl_seen;
    scl_seen = 1'b0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 1;
    while (!done0 && n < 8) begin
      if (scl_oe0 || sda_oe0) scl_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    checks++; if (done0 !== 1'b1 || n > 4) begin errors++; $display("FAIL empty_done: done=%0b after %0d clocks want 1 within 4", done0, n); end
    checks++; if (scl_seen !== 1'b0 || busy0 !== 1'b0 || error0 !== 1'b0) begin errors++; $display("FAIL empty_quiet: bus_activity=%0b busy=%0b error=%0b want 0 0 0", scl_seen, busy0, error0); end
  endtask

  task automatic test_protocol();
    checks++; if (proto_viol != 0) begin errors++; $display("FAIL protocol: got %0d violations want 0", proto_viol); end
  endtask

  initial begin
    test_reset();
    test_all_ack();
`ifdef I2C_INIT_RETRY_EN
    test_retry();
`else
    test_nack_error();
`endif
    test_reset_mid_xfer();
    test_start_while_busy();
    test_empty_table();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
